regfile_dump_reader: RTL

- Sequencer that reads the 32 x 64-bit register file through its two combinational read ports (RA/BusA, RB/BusB).
- Emits every register as a valid/ready stream of (index, value) beats to a debug/scan consumer.
- Counterpart to the register-file write path: it only reads, never drives RW/BusW/RegWr.
- Sits beside the register file in the datapath; its RA/RB are muxed onto the read ports while Busy is high.

---
 rtl/regdump_pkg.sv | 7 +
 rtl/regdump_out_stage.sv | 41 ++++
 rtl/regfile_dump_reader.sv | 111 +++++++++++
 3 files changed

// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and defaults for the register-file dump reader.
package regdump_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int ZR_IDX = 31;
  typedef enum logic [2:0] {IDLE, CAP, SEND_A, SEND_B, DONE} state_e;
endpackage

// File: rtl/regdump_out_stage.sv
// regdump_out_stage: valid/ready output holding register; loads a beat, holds it under backpressure.
module regdump_out_stage #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clr,
  input  logic          ready,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] iin,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] iout,
  output logic          accept
);
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] index_q, index_d;
  always_comb begin
    valid_d = load ? 1'b1 : clr ? 1'b0 : valid_q;
    data_d  = load ? din : data_q;
    index_d = load ? iin : index_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
    end
  end
  assign valid  = valid_q;
  assign dout   = data_q;
  assign iout   = index_q;
  assign accept = valid_q & ready;
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams every register as (index, value) beats via the two read ports.
// Define REGDUMP_SKIP_ZR_EN to omit the final (zero) register from the stream.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REGS   = ZR_IDX + 1
) (
  input  logic                  Clk,
  input  logic                  Resetb,
  input  logic                  Start,
  output logic [ADDR_WIDTH-1:0] RA,
  output logic [ADDR_WIDTH-1:0] RB,
  input  logic [DATA_WIDTH-1:0] BusA,
  input  logic [DATA_WIDTH-1:0] BusB,
  output logic                  Valid,
  input  logic                  Ready,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic [ADDR_WIDTH-1:0] Index,
  output logic                  Busy,
  output logic                  Done
);
`ifdef REGDUMP_SKIP_ZR_EN
  localparam bit SKIP_ZR = 1'b1;
`else
  localparam bit SKIP_ZR = 1'b0;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(NUM_REGS - 2);
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_WIDTH-1:0]   hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    accept, last, load, clr;
  logic [DATA_WIDTH-1:0]   load_data;
  logic [ADDR_WIDTH-1:0]   load_index;
  assign last = ptr_q == LAST_PTR;
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = Start ? CAP : IDLE;
      CAP:     state_d = SEND_A;
      SEND_A:  state_d = !accept ? SEND_A : (SKIP_ZR && last) ? DONE : SEND_B;
      SEND_B:  state_d = !accept ? SEND_B : last ? DONE : CAP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // The A beat goes out straight from the bus; the B value waits in its holding register.
  always_comb begin
    ptr_d      = ptr_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    hold_a_d   = state_q == CAP ? BusA : hold_a_q;
    hold_b_d   = state_q == CAP ? BusB : hold_b_q;
    load       = state_q == CAP || (state_q == SEND_A && accept && state_d == SEND_B);
    clr        = accept && state_d inside {CAP, DONE};
    load_data  = state_q == CAP ? hold_a_d : hold_b_q;
    load_index = state_q == CAP ? ptr_q : ptr_q + ADDR_WIDTH'(1);
    busy_d     = state_d != IDLE;
    done_d     = state_d == DONE;
    if (state_q == IDLE && Start) begin
      ptr_d = '0;
      ra_d  = '0;
      rb_d  = ADDR_WIDTH'(1);
    end
    if (state_q == SEND_B && state_d == CAP) begin
      ptr_d = ptr_q + ADDR_WIDTH'(2);
      ra_d  = ptr_q + ADDR_WIDTH'(2);
      rb_d  = ptr_q + ADDR_WIDTH'(3);
    end
  end
  regdump_out_stage #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_out (
    .clk    (Clk),
    .rst_n  (Resetb),
    .load   (load),
    .clr    (clr),
    .ready  (Ready),
    .din    (load_data),
    .iin    (load_index),
    .valid  (Valid),
    .dout   (DataOut),
    .iout   (Index),
    .accept (accept)
  );
  assign RA   = ra_q;
  assign RB   = rb_q;
  assign Busy = busy_q;
  assign Done = done_q;
endmodule
